cirno9_sram_ctrl: RTL



---
 rtl/cirno9_sram_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cirno9_sram_ctrl.sv
// Load/store-port controller for a 1-cycle-latency single-port SRAM with wait states.
// Optional bus-error detection on out-of-range addresses: CIRNO9_SRAM_CTRL_BUSERR_EN.
module cirno9_sram_ctrl #(
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 32,
  parameter int unsigned DEPTH_LOG2 = 14,
  parameter int unsigned RD_WAIT    = 1,
  parameter int unsigned WR_WAIT    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_ren,
  input  logic [DW/8-1:0]       i_wen,
  input  logic [AW-1:0]         i_adr,
  input  logic [DW-1:0]         i_wdat,
  output logic [DW-1:0]         o_rdat,
  output logic                  o_rdy,
  output logic                  o_err,
  output logic                  o_sram_en,
  output logic [DW/8-1:0]       o_sram_we,
  output logic [DEPTH_LOG2-1:0] o_sram_adr,
  output logic [DW-1:0]         o_sram_din,
  input  logic [DW-1:0]         i_sram_dout
);

  localparam int unsigned BW    = DW / 8;
  localparam int unsigned BOFF  = $clog2(BW);
  localparam int unsigned WA_HI = DEPTH_LOG2 + BOFF;
  localparam logic [4:0]  RD_LOAD = 5'(RD_WAIT + 1);
  localparam logic [4:0]  WR_LOAD = 5'(WR_WAIT);

  typedef enum logic [1:0] {IDLE, ACC, WAIT, RESP} state_e;

  state_e                  state_q;
  logic [4:0]              cnt_q;
  logic                    wr_q;
  logic                    rdy_q;
  logic                    err_q;
  logic                    sram_en_q;
  logic [BW-1:0]           sram_we_q;
  logic [DEPTH_LOG2-1:0]   sram_adr_q;
  logic [DW-1:0]           sram_din_q;
  logic [DW-1:0]           rdat_q;

  logic                    req;
  logic                    is_wr;
  logic                    oor;
  logic [DEPTH_LOG2-1:0]   word_adr;
  logic                    unused_adr_bits;

  assign req      = i_ren | (|i_wen);
  assign is_wr    = |i_wen;
  assign word_adr = i_adr[WA_HI-1:BOFF];

`ifdef CIRNO9_SRAM_CTRL_BUSERR_EN
  assign oor             = |i_adr[AW-1:WA_HI];
  assign o_err           = err_q;
  assign unused_adr_bits = ^i_adr[BOFF-1:0];
`else
  // Upper address bits alias onto the SRAM; the error path folds away.
  assign oor             = 1'b0;
  assign o_err           = 1'b0;
  assign unused_adr_bits = ^{i_adr[AW-1:WA_HI], i_adr[BOFF-1:0], err_q};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      rdy_q      <= 1'b0;
      err_q      <= 1'b0;
      sram_en_q  <= 1'b0;
      sram_we_q  <= '0;
      sram_adr_q <= '0;
      sram_din_q <= '0;
      rdat_q     <= '0;
    end else begin
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      sram_en_q <= 1'b0;
      sram_we_q <= '0;
      case (state_q)
        IDLE: begin
          if (req) begin
            if (oor) begin
              state_q <= RESP;
              rdy_q   <= 1'b1;
              err_q   <= 1'b1;
              rdat_q  <= '0;
            end else begin
              state_q    <= ACC;
              wr_q       <= is_wr;
              cnt_q      <= is_wr ? WR_LOAD : RD_LOAD;
              sram_en_q  <= 1'b1;
              sram_we_q  <= is_wr ? i_wen : '0;
              sram_adr_q <= word_adr;
              sram_din_q <= i_wdat;
            end
          end
        end
        ACC: begin
          if (cnt_q != '0) begin
            state_q <= WAIT;
          end else begin
            state_q <= RESP;
            rdy_q   <= 1'b1;
          end
        end
        WAIT: begin
          // A read's counter still holds its load value only in the first WAIT cycle.
          if (!wr_q && cnt_q == RD_LOAD) rdat_q <= i_sram_dout;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_q <= RESP;
            rdy_q   <= 1'b1;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_rdat     = rdat_q;
  assign o_rdy      = rdy_q;
  assign o_sram_en  = sram_en_q;
  assign o_sram_we  = sram_we_q;
  assign o_sram_adr = sram_adr_q;
  assign o_sram_din = sram_din_q;

endmodule
